// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for four requesters sharing one multiplexed data path.
// The granted word is registered and presented downstream over valid/ready.
// After each transfer the path drops back to IDLE for one cycle, and the
// requester that was just served becomes the lowest priority.
module rr_mux_arbiter4 #(
   parameter int unsigned DATA_WIDTH = 3,
   parameter int unsigned SEL_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            req,
   input  logic [DATA_WIDTH-1:0] in0,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [DATA_WIDTH-1:0] in3,
   output logic [3:0]            ack,
   output logic [3:0]            grant,
   output logic [SEL_WIDTH-1:0]  sel,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
   logic [3:0]            grant_d;
   logic [SEL_WIDTH-1:0]  sel_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  valid_d;

   logic                  found;
   logic [SEL_WIDTH-1:0]  pick;
   logic [SEL_WIDTH-1:0]  idx;
   logic [DATA_WIDTH-1:0] pick_data;

   // A requester's word is accepted in the cycle the consumer takes it.
   assign ack = grant & {4{out_valid & out_ready}};

   // Round-robin search from ptr, the data mux, and next-state/output logic.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant;
      sel_d     = sel;
      data_d    = out_data;
      valid_d   = out_valid;
      found     = 1'b0;
      pick      = '0;
      idx       = '0;
      pick_data = '0;

      // Walk from the farthest offset down so the one nearest ptr wins.
      for (int i = 3; i >= 0; i--) begin
         idx = ptr_q + SEL_WIDTH'(i);
         if (req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (pick)
         2'd0:    pick_data = in0;
         2'd1:    pick_data = in1;
         2'd2:    pick_data = in2;
         default: pick_data = in3;
      endcase

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = 4'(1) << pick;
               sel_d   = pick;
               data_d  = pick_data;
               valid_d = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // The word is held until the consumer takes it; req is ignored here.
            if (out_ready) begin
               ptr_d   = sel + SEL_WIDTH'(1);
               grant_d = 4'b0000;
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = 4'b0000;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         grant     <= 4'b0000;
         sel       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant     <= grant_d;
         sel       <= sel_d;
         out_data  <= data_d;
         out_valid <= valid_d;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed bench for rr_mux_arbiter4: reset, idle, single request, fairness,
// wrap-around, backpressure and reset during a transfer.
module tb_rr_mux_arbiter4;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [2:0] in0, in1, in2, in3;
   logic [3:0] ack;
   logic [3:0] grant;
   logic [1:0] sel;
   logic [2:0] out_data;
   logic       out_valid;
   logic       out_ready;

   int checks   = 0;
   int failures = 0;

   rr_mux_arbiter4 dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .ack       (ack),
      .grant     (grant),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                          input logic [2:0] d, input logic v, input logic [3:0] a);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".sel"}, 32'(sel), 32'(s));
      chk({tag, ".data"}, 32'(out_data), 32'(d));
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".ack"}, 32'(ack), 32'(a));
   endtask

   initial begin
      logic [3:0] fair_grant [5];
      logic [1:0] fair_sel   [5];
      logic [2:0] fair_data  [5];

      fair_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      fair_sel   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      fair_data  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

      reset = 1'b1; req = 4'b0000; out_ready = 1'b0;
      in0 = 3'd0; in1 = 3'd0; in2 = 3'd0; in3 = 3'd0;
      tick();
      tick();
      chk_all("reset", 4'b0000, 2'd0, 3'd0, 1'b0, 4'b0000);
      reset = 1'b0;

      // Idle with no requests.
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_all("idle", 4'b0000, 2'd0, 3'd0, 1'b0, 4'b0000);
      end

      // Single requester 2, consumer ready.
      req = 4'b0100; in2 = 3'b101; out_ready = 1'b1;
      tick();
      chk_all("single_grant", 4'b0100, 2'd2, 3'b101, 1'b1, 4'b0100);
      req = 4'b0000;
      tick();
      chk_all("single_done", 4'b0000, 2'd2, 3'b101, 1'b0, 4'b0000);

      // ptr is now 3, so requester 3 wins first with everyone requesting.
      in0 = 3'd1; in1 = 3'd2; in2 = 3'd3; in3 = 3'd4;
      req = 4'b1111;
      tick();
      chk_all("ptr3_grant", 4'b1000, 2'd3, 3'd4, 1'b1, 4'b1000);
      tick();
      chk_all("ptr3_done", 4'b0000, 2'd3, 3'd4, 1'b0, 4'b0000);

      // Fairness: grants rotate 0,1,2,3,0 with an idle bubble between.
      for (int n = 0; n < 5; n++) begin
         tick();
         chk_all("fair_grant", fair_grant[n], fair_sel[n], fair_data[n], 1'b1, fair_grant[n]);
         tick();
         chk_all("fair_bubble", 4'b0000, fair_sel[n], fair_data[n], 1'b0, 4'b0000);
      end

      // ptr=1: serve requester 3 so ptr wraps to 0, then 0 beats 3.
      req = 4'b1000;
      tick();
      chk_all("wrap_pre", 4'b1000, 2'd3, 3'd4, 1'b1, 4'b1000);
      tick();
      req = 4'b1001;
      tick();
      chk_all("wrap_grant", 4'b0001, 2'd0, 3'd1, 1'b1, 4'b0001);
      tick();
      chk_all("wrap_done", 4'b0000, 2'd0, 3'd1, 1'b0, 4'b0000);

      // Backpressure on requester 1 (ptr=1).
      out_ready = 1'b0; in1 = 3'b110; req = 4'b1111;
      tick();
      chk_all("bp_grant", 4'b0010, 2'd1, 3'b110, 1'b1, 4'b0000);
      in1 = 3'b001;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all("bp_stall", 4'b0010, 2'd1, 3'b110, 1'b1, 4'b0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ack", 32'(ack), 32'(4'b0010));
      tick();
      chk_all("bp_done", 4'b0000, 2'd1, 3'b110, 1'b0, 4'b0000);
      tick();
      chk_all("bp_next", 4'b0100, 2'd2, 3'd3, 1'b1, 4'b0100);
      tick();

      // Reset in the middle of a stalled transfer (ptr=3).
      out_ready = 1'b0;
      tick();
      chk_all("rst_busy", 4'b1000, 2'd3, 3'd4, 1'b1, 4'b0000);
      tick();
      reset = 1'b1;
      #1;
      chk("rst_noack", 32'(ack), 32'(4'b0000));
      tick();
      chk_all("rst_mid", 4'b0000, 2'd0, 3'd0, 1'b0, 4'b0000);
      reset = 1'b0;
      tick();
      chk_all("rst_after", 4'b0001, 2'd0, 3'd1, 1'b1, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
